// File: rtl/trivium_stream_ctrl.sv
// Sequencer for a bit-serial Trivium core: latches key/IV, loads and warms up the core,
// then packs keystream bits LSB-first into bytes and XORs them onto a plaintext byte stream.
module trivium_stream_ctrl #(
  parameter int WARMUP_CYCLES = 1152,
  parameter int LEN_W         = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [79:0]      key_i,
  input  logic [79:0]      iv_i,
  input  logic [LEN_W-1:0] msg_len_i,
  input  logic             pt_valid_i,
  output logic             pt_ready_o,
  input  logic [7:0]       pt_data_i,
  output logic             ct_valid_o,
  input  logic             ct_ready_i,
  output logic [7:0]       ct_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             core_load_o,
  output logic [79:0]      core_key_o,
  output logic [79:0]      core_iv_o,
  output logic             core_step_o,
  output logic             core_init_o,
  input  logic             core_ks_i
);

  localparam int WCNT_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, WARMUP, GATHER, HOLD, FLUSH} state_e;

  state_e             state_q, state_d;
  logic [79:0]        key_q, key_d;
  logic [79:0]        iv_q, iv_d;
  logic [LEN_W-1:0]   bytes_left_q, bytes_left_d;
  logic [WCNT_W-1:0]  warm_cnt_q, warm_cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         ks_byte_q, ks_byte_d;
  logic               ks_full_q, ks_full_d;
  logic               ct_valid_q, ct_valid_d;
  logic [7:0]         ct_data_q, ct_data_d;
  logic               done_q, done_d;
  logic               pt_hs, ct_hs;

  // A new plaintext byte may enter when the held ciphertext slot is free or leaving this cycle.
  assign pt_ready_o = (state_q == HOLD) && ks_full_q && (!ct_valid_q || ct_ready_i);
  assign pt_hs      = pt_ready_o && pt_valid_i;
  assign ct_hs      = ct_valid_q && ct_ready_i;

  assign ct_valid_o  = ct_valid_q;
  assign ct_data_o   = ct_data_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q != IDLE);
  assign core_load_o = (state_q == LOAD);
  assign core_step_o = (state_q == WARMUP) || (state_q == GATHER);
  assign core_init_o = (state_q == WARMUP);
  assign core_key_o  = key_q;
  assign core_iv_o   = iv_q;

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    iv_d         = iv_q;
    bytes_left_d = bytes_left_q;
    warm_cnt_d   = warm_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    ks_byte_d    = ks_byte_q;
    ks_full_d    = ks_full_q;
    ct_valid_d   = ct_valid_q;
    ct_data_d    = ct_data_q;
    done_d       = 1'b0;

    if (ct_hs) ct_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (msg_len_i == '0) begin
            done_d = 1'b1;
          end else begin
            key_d        = key_i;
            iv_d         = iv_i;
            bytes_left_d = msg_len_i;
            state_d      = LOAD;
          end
        end
      end
      LOAD: begin
        warm_cnt_d = '0;
        state_d    = WARMUP;
      end
      WARMUP: begin
        warm_cnt_d = warm_cnt_q + WCNT_W'(1);
        if (warm_cnt_q == WCNT_W'(WARMUP_CYCLES - 1)) begin
          bit_cnt_d = '0;
          state_d   = GATHER;
        end
      end
      GATHER: begin
        ks_byte_d[bit_cnt_q] = core_ks_i;
        bit_cnt_d            = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          ks_full_d = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (pt_hs) begin
          ct_data_d    = pt_data_i ^ ks_byte_q;
          ct_valid_d   = 1'b1;
          ks_full_d    = 1'b0;
          bytes_left_d = bytes_left_q - LEN_W'(1);
          state_d      = (bytes_left_q == LEN_W'(1)) ? FLUSH : GATHER;
        end
      end
      FLUSH: begin
        if (ct_hs) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything, including a start seen in the same cycle.
    if (abort_i) begin
      state_d      = IDLE;
      key_d        = '0;
      iv_d         = '0;
      bytes_left_d = '0;
      warm_cnt_d   = '0;
      bit_cnt_d    = '0;
      ks_full_d    = 1'b0;
      ct_valid_d   = 1'b0;
      done_d       = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      key_q        <= '0;
      iv_q         <= '0;
      bytes_left_q <= '0;
      warm_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      ks_byte_q    <= '0;
      ks_full_q    <= 1'b0;
      ct_valid_q   <= 1'b0;
      ct_data_q    <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      iv_q         <= iv_d;
      bytes_left_q <= bytes_left_d;
      warm_cnt_q   <= warm_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      ks_byte_q    <= ks_byte_d;
      ks_full_q    <= ks_full_d;
      ct_valid_q   <= ct_valid_d;
      ct_data_q    <= ct_data_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_trivium_stream_ctrl.sv
// Bench for trivium_stream_ctrl: a Trivium core model feeds core_ks, and a scoreboard
// of expected ciphertext bytes is checked by a monitor independent of the stimulus.
module tb_trivium_stream_ctrl;

  localparam int W     = 1152;
  localparam int LEN_W = 16;

  logic             clk, rst, start, abort;
  logic [79:0]      key, iv;
  logic [LEN_W-1:0] msgLen;
  logic             ptValid, ptReady, ctValid, ctReady;
  logic [7:0]       ptData, ctData;
  logic             busy, done, coreLoad, coreStep, coreInit, coreKs;
  logic [79:0]      coreKey, coreIv;

  trivium_stream_ctrl #(.WARMUP_CYCLES(W), .LEN_W(LEN_W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .key_i(key), .iv_i(iv), .msg_len_i(msgLen),
    .pt_valid_i(ptValid), .pt_ready_o(ptReady), .pt_data_i(ptData),
    .ct_valid_o(ctValid), .ct_ready_i(ctReady), .ct_data_o(ctData),
    .busy_o(busy), .done_o(done), .core_load_o(coreLoad),
    .core_key_o(coreKey), .core_iv_o(coreIv),
    .core_step_o(coreStep), .core_init_o(coreInit), .core_ks_i(coreKs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;
  int stepCount, loadCount, doneCount, busyHigh, firstPtReady, doneCycle;
  logic [7:0] ptQ[$];
  logic [7:0] expQ[$];
  logic [287:0] coreState;

  // Reference Trivium: s1..s288 held at bit indices 0..287, K1 = key[0], IV1 = iv[0].
  function automatic logic [287:0] trivLoad(input logic [79:0] k, input logic [79:0] v);
    logic [287:0] s;
    s = '0;
    s[79:0]   = k;
    s[172:93] = v;
    s[287:285] = 3'b111;
    return s;
  endfunction

  function automatic logic trivZ(input logic [287:0] s);
    return s[65] ^ s[92] ^ s[161] ^ s[176] ^ s[242] ^ s[287];
  endfunction

  function automatic logic [287:0] trivStep(input logic [287:0] s);
    logic t1, t2, t3;
    logic [287:0] n;
    t1 = s[65] ^ s[92] ^ (s[90] & s[91]) ^ s[170];
    t2 = s[161] ^ s[176] ^ (s[174] & s[175]) ^ s[263];
    t3 = s[242] ^ s[287] ^ (s[285] & s[286]) ^ s[68];
    n[92:0]    = {s[91:0], t3};
    n[176:93]  = {s[175:93], t1};
    n[287:177] = {s[286:177], t2};
    return n;
  endfunction

  // Core model: output reflects state before the step taken on the same edge.
  assign coreKs = trivZ(coreState);
  always @(posedge clk or posedge rst) begin
    if (rst) coreState <= '0;
    else if (coreLoad) coreState <= trivLoad(coreKey, coreIv);
    else if (coreStep) coreState <= trivStep(coreState);
  end

  always @(posedge clk) cycleCnt++;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] outVec();
    return 256'({ptReady, ctValid, ctData, busy, done, coreLoad, coreKey, coreIv, coreStep, coreInit});
  endfunction

  // Monitor: observation counters and scoreboard pop on every ciphertext handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (coreStep) stepCount++;
      if (coreLoad) loadCount++;
      if (busy) busyHigh++;
      if (done) begin
        doneCount++;
        doneCycle = cycleCnt;
      end
      if (ptReady && firstPtReady < 0) firstPtReady = cycleCnt;
      if (ctValid && ctReady) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL ctUnexpected: got byte %0h with no byte expected", ctData);
        end else begin
          checkOutput("ctByte", 256'(ctData), 256'(expQ.pop_front()));
        end
      end
    end
  end

  // Plaintext driver: presents queued bytes and retires them on handshake.
  initial begin
    logic hs;
    ptValid = 1'b0;
    ptData  = 8'h00;
    forever begin
      @(negedge clk);
      hs = ptValid && ptReady;
      @(posedge clk);
      #1;
      if (hs && ptQ.size() > 0) ptQ.delete(0);
      if (ptQ.size() > 0) begin
        ptValid = 1'b1;
        ptData  = ptQ[0];
      end else begin
        ptValid = 1'b0;
        ptData  = 8'h00;
      end
    end
  end

  task automatic clearObs();
    stepCount    = 0;
    loadCount    = 0;
    doneCount    = 0;
    busyHigh     = 0;
    firstPtReady = -1;
    doneCycle    = -1;
  endtask

  task automatic applyStimulus(input logic [79:0] k, input logic [79:0] v, input int len,
                               input logic [7:0] ptBase, input logic [7:0] ptStep,
                               output int c0);
    logic [287:0] s;
    logic [7:0] ks, ptv;
    s = trivLoad(k, v);
    repeat (W) s = trivStep(s);
    for (int i = 0; i < len; i++) begin
      for (int b = 0; b < 8; b++) begin
        ks[b] = trivZ(s);
        s = trivStep(s);
      end
      ptv = ptBase + 8'(i) * ptStep;
      ptQ.push_back(ptv);
      expQ.push_back(ptv ^ ks);
    end
    clearObs();
    key    = k;
    iv     = v;
    msgLen = LEN_W'(len);
    start  = 1'b1;
    c0     = cycleCnt;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget, input string name);
    int n = 0;
    while (doneCount == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (doneCount == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: done not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic waitCtValid(input int budget, input string name);
    int n = 0;
    while (!ctValid && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!ctValid) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: ct_valid not seen within %0d cycles", name, budget);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0;
    logic [7:0] d0;
    logic stable, ptHigh;

    rst = 1'b1; start = 1'b0; abort = 1'b0; key = '0; iv = '0; msgLen = '0; ctReady = 1'b0;
    clearObs();
    repeat (3) @(posedge clk);
    #2;
    checkOutput("resetOutputs", outVec(), 256'd0);
    rst = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("idleOutputs", outVec(), 256'd0);

    $display("[TB] zero-length session");
    clearObs();
    msgLen = '0;
    key    = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    start  = 1'b1;
    c0     = cycleCnt;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    checkOutput("zeroLenDoneCount", 256'(doneCount), 256'd1);
    checkOutput("zeroLenDoneCycle", 256'(doneCycle), 256'(c0 + 1));
    checkOutput("zeroLenBusy", 256'(busyHigh), 256'd0);
    checkOutput("zeroLenCoreActivity", 256'(loadCount + stepCount), 256'd0);

    $display("[TB] zero key/iv, four zero bytes");
    ctReady = 1'b1;
    applyStimulus(80'h0, 80'h0, 4, 8'h00, 8'h00, c0);
    waitDone(1400, "zeroKeyDone");
    repeat (3) @(posedge clk);
    #2;
    checkOutput("zeroKeySteps", 256'(stepCount), 256'(W + 32));
    checkOutput("zeroKeyFirstPtReady", 256'(firstPtReady - c0), 256'd1162);
    checkOutput("zeroKeyLoads", 256'(loadCount), 256'd1);
    checkOutput("zeroKeyDoneCount", 256'(doneCount), 256'd1);
    checkOutput("zeroKeyLeftover", 256'(expQ.size()), 256'd0);
    checkOutput("zeroKeyBusyAfter", 256'(busy), 256'd0);

    $display("[TB] downstream stall");
    ctReady = 1'b0;
    applyStimulus(80'h0123_4567_89AB_CDEF_1357, 80'hFEDC_BA98_7654_3210_2468, 3, 8'h5A, 8'h11, c0);
    waitCtValid(1400, "stallFirstCt");
    d0 = ctData;
    stable = 1'b1;
    ptHigh = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (!ctValid || ctData !== d0) stable = 1'b0;
      if (ptReady) ptHigh = 1'b1;
    end
    checkOutput("stallCtStable", 256'(stable), 256'd1);
    checkOutput("stallPtReady", 256'(ptHigh), 256'd0);
    checkOutput("stallSteps", 256'(stepCount), 256'(W + 16));
    @(posedge clk);
    #2;
    ctReady = 1'b1;
    waitDone(200, "stallDone");
    repeat (3) @(posedge clk);
    #2;
    checkOutput("stallDoneCount", 256'(doneCount), 256'd1);
    checkOutput("stallTotalSteps", 256'(stepCount), 256'(W + 24));
    checkOutput("stallLeftover", 256'(expQ.size()), 256'd0);

    $display("[TB] abort during warm-up");
    clearObs();
    key    = 80'hAAAA_5555_AAAA_5555_AAAA;
    iv     = 80'h1;
    msgLen = LEN_W'(5);
    start  = 1'b1;
    c0     = cycleCnt;
    @(posedge clk);
    #2;
    start = 1'b0;
    while (cycleCnt < c0 + 500) begin
      @(posedge clk);
      #2;
    end
    abort = 1'b1;
    @(posedge clk);
    #2;
    abort = 1'b0;
    checkOutput("abortBusy", 256'({busy, coreStep, coreInit, ctValid, ptReady}), 256'd0);
    repeat (20) @(posedge clk);
    #2;
    checkOutput("abortNoDone", 256'(doneCount), 256'd0);
    applyStimulus(80'h0F0F_0F0F_0F0F_0F0F_0F0F, 80'h8000_0000_0000_0000_0001, 2, 8'hC3, 8'h3C, c0);
    waitDone(1400, "afterAbortDone");
    checkOutput("afterAbortFirstPtReady", 256'(firstPtReady - c0), 256'(W + 10));
    checkOutput("afterAbortSteps", 256'(stepCount), 256'(W + 16));

    $display("[TB] start while busy");
    applyStimulus(80'h1234_5678_9ABC_DEF0_1122, 80'h3344_5566_7788_99AA_BBCC, 2, 8'h01, 8'h02, c0);
    repeat (100) @(posedge clk);
    #2;
    key    = 80'hDEAD_BEEF_DEAD_BEEF_DEAD;
    iv     = 80'hCAFE;
    msgLen = LEN_W'(7);
    start  = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    waitDone(1400, "busyStartDone");
    repeat (3) @(posedge clk);
    #2;
    checkOutput("busyStartLoads", 256'(loadCount), 256'd1);
    checkOutput("busyStartSteps", 256'(stepCount), 256'(W + 16));
    checkOutput("busyStartLeftover", 256'(expQ.size()), 256'd0);

    $display("[TB] reset during HOLD with pending byte");
    ctReady = 1'b0;
    applyStimulus(80'h7777_8888_9999_AAAA_BBBB, 80'h2, 2, 8'h44, 8'h01, c0);
    waitCtValid(1400, "resetFirstCt");
    repeat (12) @(posedge clk);
    #2;
    checkOutput("resetPreHold", 256'({ctValid, busy, coreStep}), 256'b110);
    rst = 1'b1;
    #1;
    checkOutput("resetMidSession", outVec(), 256'd0);
    ptQ.delete();
    expQ.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    checkOutput("resetNoDone", 256'({doneCount != 0, busy}), 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
